// File: rtl/regfile_arbiter.sv
// Round-robin access arbiter for the 32-entry register file.
// After reset it clears every register, then grants one read or write per cycle.
module regfile_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      init_done,
  output logic                      rf_read_en_1,
  output logic                      rf_read_en_2,
  output logic [ADDR_W-1:0]         rf_read_addr_1,
  output logic [ADDR_W-1:0]         rf_read_addr_2,
  output logic                      rf_write_en,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  input  logic [DATA_W-1:0]         rf_read_data_1
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [PTR_W-1:0]   ptr;
  logic               done_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;

  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   scan;
  logic [NUM_REQ-1:0] gnt;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               rd_gnt;

  // Scan requesters starting at the pointer; the first valid one wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = PTR_W'((32'(ptr) + k) % NUM_REQ);
      if (!gnt_any && (state == ST_RUN) && req_valid[scan]) begin
        gnt_any = 1'b1;
        gnt_idx = scan;
      end
    end
  end

  always_comb begin
    gnt       = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    sel_we    = req_we[gnt_idx];
    sel_addr  = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[32'(gnt_idx)*DATA_W +: DATA_W];
    rd_gnt    = gnt_any & ~sel_we;
  end

  // Port drive; everything is held at zero while reset is asserted.
  always_comb begin
    req_ready      = '0;
    rf_read_en_1   = 1'b0;
    rf_read_en_2   = 1'b0;
    rf_read_addr_1 = '0;
    rf_read_addr_2 = '0;
    rf_write_en    = 1'b0;
    rf_write_addr  = '0;
    rf_write_data  = '0;
    rsp_valid      = '0;
    rsp_rdata      = '0;
    init_done      = 1'b0;
    if (!reset) begin
      rsp_valid = rsp_valid_q;
      rsp_rdata = rsp_rdata_q;
      init_done = done_q;
      if (state == ST_INIT) begin
        rf_write_en   = 1'b1;
        rf_write_addr = clr_cnt;
      end else if (gnt_any) begin
        req_ready = gnt;
        if (sel_we) begin
          // Register 0 is hardwired zero: the handshake completes but nothing is written.
          if (sel_addr != '0) begin
            rf_write_en   = 1'b1;
            rf_write_addr = sel_addr;
            rf_write_data = sel_wdata;
          end
        end else begin
          rf_read_en_1   = 1'b1;
          rf_read_addr_1 = sel_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INIT;
      clr_cnt     <= '0;
      ptr         <= '0;
      done_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt     <= clr_cnt + ADDR_W'(1);
          rsp_valid_q <= '0;
          rsp_rdata_q <= '0;
          if (clr_cnt == LAST_ADDR) begin
            state  <= ST_RUN;
            done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          rsp_valid_q <= rd_gnt ? gnt : '0;
          rsp_rdata_q <= rd_gnt ? rf_read_data_1 : '0;
          if (gnt_any) begin
            ptr <= PTR_W'((32'(gnt_idx) + 1) % NUM_REQ);
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with an attached behavioural register file.
module tb_regfile_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            init_done;
  logic            rf_read_en_1;
  logic            rf_read_en_2;
  logic [AW-1:0]   rf_read_addr_1;
  logic [AW-1:0]   rf_read_addr_2;
  logic            rf_write_en;
  logic [AW-1:0]   rf_write_addr;
  logic [DW-1:0]   rf_write_data;
  logic [DW-1:0]   rf_read_data_1;

  regfile_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .rf_read_en_1(rf_read_en_1), .rf_read_en_2(rf_read_en_2),
    .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_read_data_1(rf_read_data_1)
  );

  // Register file attached to the DUT: write at the edge, combinational read.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) if (rf_write_en) rf_mem[rf_write_addr] <= rf_write_data;
  assign rf_read_data_1 = rf_read_en_1 ? rf_mem[rf_read_addr_1] : '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_vec  = 0;
  int          n_fail = 0;
  int          ref_ptr;
  logic [31:0] ref_mem [32];
  bit          pv   [N];
  bit          pwe  [N];
  logic [4:0]  pa   [N];
  logic [31:0] pw   [N];
  bit          glast[N];

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pv[i];
      req_we[i]            = pwe[i];
      req_addr[i*AW +: AW] = pa[i];
      req_wdata[i*DW +: DW] = pw[i];
    end
  endtask

  task automatic set_req(int i, bit v, bit we, logic [4:0] a, logic [31:0] d);
    pv[i] = v; pwe[i] = we; pa[i] = a; pw[i] = d;
  endtask

  task automatic model_clear();
    ref_ptr = 0;
    for (int a = 0; a < 32; a++) ref_mem[a] = '0;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b0, 1'b0, 5'd0, 32'd0);
      glast[i] = 1'b0;
    end
  endtask

  task automatic check_zero();
    check("reset_outputs",
          {req_ready, rsp_valid, rsp_rdata, init_done, rf_read_en_1, rf_read_en_2,
           rf_read_addr_1, rf_read_addr_2, rf_write_en, rf_write_addr, rf_write_data}, '0);
  endtask

  // Entered one time unit after a rising edge; returns at the same phase.
  task automatic do_reset();
    reset = 1'b1;
    sbq.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'(i), 5'(3 + i), 32'hA5A5_0000 + 32'(i));
    apply();
    #2;
    check_zero();
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic init_seq(int n);
    for (int c = 0; c < n; c++) begin
      #2;
      check("init_write", {rf_write_en, rf_write_addr, rf_write_data}, {1'b1, 5'(c), 32'd0});
      check("init_quiet", {req_ready, init_done, rsp_valid, rf_read_en_1}, '0);
      @(posedge clk); #1;
    end
  endtask

  // One RUN cycle against the round-robin reference model.
  task automatic step();
    int          g;
    logic [N-1:0] exp_ready;
    logic         exp_wen, exp_ren;
    logic [4:0]   exp_waddr, exp_raddr;
    logic [31:0]  exp_wdata;
    g = -1;
    #2;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ref_ptr + k) % N;
      if (g < 0 && pv[i]) g = i;
    end
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    exp_wen   = (g >= 0) && pwe[g] && (pa[g] != 5'd0);
    exp_waddr = exp_wen ? pa[g] : 5'd0;
    exp_wdata = exp_wen ? pw[g] : 32'd0;
    exp_ren   = (g >= 0) && !pwe[g];
    exp_raddr = exp_ren ? pa[g] : 5'd0;
    check("init_done", init_done, 1);
    check("grant", req_ready, exp_ready);
    check("write_port", {rf_write_en, rf_write_addr, rf_write_data}, {exp_wen, exp_waddr, exp_wdata});
    check("read_port", {rf_read_en_1, rf_read_addr_1, rf_read_en_2, rf_read_addr_2},
          {exp_ren, exp_raddr, 1'b0, 5'd0});
    for (int i = 0; i < N; i++) glast[i] = 1'b0;
    if (g >= 0) begin
      glast[g] = 1'b1;
      ref_ptr  = (g + 1) % N;
      if (pwe[g]) begin
        if (pa[g] != 5'd0) ref_mem[pa[g]] = pw[g];
      end else begin
        sbq.push_back('{g, ref_mem[pa[g]], cyc + 1});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_cycle();
    for (int i = 0; i < N; i++) begin
      if (!pv[i] || glast[i]) begin
        pv[i]  = ($urandom_range(0, 99) < 65);
        pwe[i] = 1'($urandom_range(0, 1));
        pa[i]  = 5'($urandom_range(0, 7));
        pw[i]  = $urandom;
      end
    end
    apply();
    step();
  endtask

  // Response monitor: pops the scoreboard whenever a response strobe appears.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("rsp_valid", {rsp_valid, 32'(cyc)}, {N'(1) << mon_e.idx, 32'(mon_e.cyc)});
          check("rsp_rdata", rsp_rdata, mon_e.data);
        end
      end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        check("missing_rsp", rsp_valid, N'(1) << sbq[0].idx);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 32; a++) rf_mem[a] = $urandom;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

    // Clear sequence with requests pending the whole time.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 5'(9 + i), 32'd0);
    apply();
    init_seq(32);

    // Both requesters hold valid: grants must alternate from requester 0.
    set_req(0, 1'b1, 1'b0, 5'd18, 32'd0);
    set_req(1, 1'b1, 1'b1, 5'd7, 32'd191);
    apply();
    repeat (6) step();

    // Write then read back the same address on consecutive cycles.
    set_req(1, 1'b0, 1'b0, 5'd0, 32'd0);
    set_req(0, 1'b1, 1'b1, 5'd18, 32'd3108);
    apply(); step();
    set_req(0, 1'b1, 1'b0, 5'd18, 32'd0);
    apply(); step();
    set_req(0, 1'b0, 1'b0, 5'd0, 32'd0);
    apply(); step();

    // Writes to register 0 complete but leave it zero.
    set_req(1, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    apply(); step();
    set_req(1, 1'b1, 1'b0, 5'd0, 32'd0);
    apply(); step();
    set_req(1, 1'b0, 1'b0, 5'd0, 32'd0);
    apply(); step(); step();

    // Reset while the clear counter is at 10.
    do_reset();
    apply();
    init_seq(10);
    do_reset();
    apply();
    init_seq(32);

    repeat (300) rand_cycle();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 5'd0, 32'd0);
    apply(); step(); step();

    // Read granted, then reset in the next cycle: the response must vanish.
    set_req(0, 1'b1, 1'b0, 5'd11, 32'd0);
    apply(); step();
    do_reset();
    apply();
    init_seq(32);
    repeat (3) step();

    check("sb_drained", 128'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
